// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
//  Module      : mem_bus_arbiter_if
//  Description : Bundle of the two requester ports and the memory port of
//                mem_bus_arbiter.
//                slave  modport : the arbiter side (serves the requests and
//                                 drives the memory).
//                master modport : the requester / memory-model side.
//  Signals     : mX_req/we/addr/wdata   request from requester X
//                mX_gnt / mX_rvalid     grant pulse, read-data-valid pulse
//                rdata                  shared read data
//                mem_addr/mem_dout/mem_w registered memory address/data/strobe
//                mem_din                memory read data
//                busy                   arbiter is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_w;
    logic [DATA_W-1:0] mem_din;
    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_din,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        output rdata, mem_addr, mem_dout, mem_w, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_din,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        input  rdata, mem_addr, mem_dout, mem_w, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Two-requester arbiter / sequencer for a shared single-port
//                synchronous memory. Requester 0 is the processor port,
//                requester 1 the DMA/peripheral engine. One access at a time;
//                round-robin on ties. Read data is returned with a one-cycle
//                rvalid pulse to the requester that was granted.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - mem_bus_arbiter_if.slave (requesters + memory)
//  Parameters  : ADDR_W  address width
//                DATA_W  data width
//                MEM_LAT memory read latency (1..4), from the edge at which
//                        the memory samples the address to data on mem_din
//  Options     : `define ARB_FIXED_PRIO_EN -> requester 0 always wins ties
//                (no last-grant register). Default: round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_bus_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // WAIT is entered one cycle after the memory sampled the address, so the
    // counter starts at MEM_LAT-1 and data is captured when it reaches zero.
    localparam logic [1:0] c_lat_init = 2'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
    logic              mem_w_q, mem_w_d;
    logic              id_q, id_d;      // winner of the current access
    logic              we_q, we_d;      // current access is a write
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              w_any_req;
    logic              w_win;           // requester id chosen this cycle

    assign w_any_req = bus.m0_req | bus.m1_req;

`ifdef ARB_FIXED_PRIO_EN
    // Requester 1 only gets through when requester 0 is not asking.
    assign w_win = ~bus.m0_req;
`else
    logic last_q, last_d;

    // On a tie the requester that did not win last time is served.
    assign w_win = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && w_any_req) begin
            last_d = w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;     // requester 0 wins the first tie
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        mem_w_d    = 1'b0;          // strobe is a single-cycle pulse
        id_d       = id_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (w_any_req) begin
                    mem_addr_d = w_win ? bus.m1_addr  : bus.m0_addr;
                    mem_dout_d = w_win ? bus.m1_wdata : bus.m0_wdata;
                    mem_w_d    = w_win ? bus.m1_we    : bus.m0_we;
                    we_d       = w_win ? bus.m1_we    : bus.m0_we;
                    id_d       = w_win;
                    state_d    = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = c_lat_init;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = bus.mem_din;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            mem_w_q    <= 1'b0;
            id_q       <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= 2'd0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            mem_w_q    <= mem_w_d;
            id_q       <= id_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    // Grant is visible for the single ACCESS cycle, rvalid for the single
    // RESP cycle; both decode registered state, so only the winner sees them.
    assign bus.m0_gnt    = (state_q == S_ACCESS) & ~id_q;
    assign bus.m1_gnt    = (state_q == S_ACCESS) &  id_q;
    assign bus.m0_rvalid = (state_q == S_RESP)   & ~id_q;
    assign bus.m1_rvalid = (state_q == S_RESP)   &  id_q;

    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_dout  = mem_dout_q;
    assign bus.mem_w     = mem_w_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter. Stimulus pushes the
//                expected grants / read responses into queues; monitors pop
//                and compare whenever the DUT shows gnt or rvalid. A second
//                instance runs with MEM_LAT=3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus  ();
    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // Memory content model
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A00);
    endfunction

    // Memory models: a read is sampled in the grant cycle; anything else
    // returns a poison value so early/late capture is visible.
    logic [15:0] pipe1 = 16'hDEAD;
    logic [15:0] p3 [3] = '{16'hDEAD, 16'hDEAD, 16'hDEAD};

    always @(posedge clk) begin
        pipe1 <= ((bus.m0_gnt | bus.m1_gnt) && !bus.mem_w) ? mem_f(bus.mem_addr) : 16'hDEAD;
        p3[0] <= ((bus3.m0_gnt | bus3.m1_gnt) && !bus3.mem_w) ? mem_f(bus3.mem_addr) : 16'hDEAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus.mem_din  = pipe1;
    assign bus3.mem_din = p3[2];

    // Scoreboard
    typedef struct {
        logic        id;
        int          cyc;
        logic [15:0] addr;
        logic [15:0] dout;
        logic        we;
    } gnt_t;

    typedef struct {
        logic        id;
        int          cyc;
        logic [15:0] data;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    rsp_t rq3[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_gnt(input logic id, input int c, input logic [15:0] a,
                           input logic [15:0] d, input logic we);
        gnt_t g;
        g.id = id; g.cyc = c; g.addr = a; g.dout = d; g.we = we;
        gq.push_back(g);
    endtask

    task automatic exp_rsp(input logic id, input int c, input logic [15:0] d);
        rsp_t r;
        r.id = id; r.cyc = c; r.data = d;
        rq.push_back(r);
    endtask

    // Monitor for the MEM_LAT=1 instance
    gnt_t mg;
    rsp_t mr;
    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_onehot", 32'(bus.m0_gnt & bus.m1_gnt), 0);
            chk("rvalid_onehot", 32'(bus.m0_rvalid & bus.m1_rvalid), 0);
            if (bus.m0_gnt || bus.m1_gnt) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", {bus.m1_gnt, bus.m0_gnt}, 0);
                end else begin
                    mg = gq.pop_front();
                    chk("gnt_id", 32'(bus.m1_gnt), 32'(mg.id));
                    chk("gnt_cycle", cyc, mg.cyc);
                    chk("mem_addr", bus.mem_addr, mg.addr);
                    chk("mem_w", 32'(bus.mem_w), 32'(mg.we));
                    if (mg.we) chk("mem_dout", bus.mem_dout, mg.dout);
                    chk("busy_at_gnt", 32'(bus.busy), 1);
                end
            end else begin
                chk("mem_w_no_gnt", 32'(bus.mem_w), 0);
            end
            if (bus.m0_rvalid || bus.m1_rvalid) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", {bus.m1_rvalid, bus.m0_rvalid}, 0);
                end else begin
                    mr = rq.pop_front();
                    chk("rvalid_id", 32'(bus.m1_rvalid), 32'(mr.id));
                    chk("rvalid_cycle", cyc, mr.cyc);
                    chk("rdata", bus.rdata, mr.data);
                end
            end
        end
    end

    // Monitor for the MEM_LAT=3 instance
    rsp_t mr3;
    always @(negedge clk) begin
        if (!rst && (bus3.m0_rvalid || bus3.m1_rvalid)) begin
            if (rq3.size() == 0) begin
                chk("lat3_rvalid_unexpected", {bus3.m1_rvalid, bus3.m0_rvalid}, 0);
            end else begin
                mr3 = rq3.pop_front();
                chk("lat3_rvalid_id", 32'(bus3.m1_rvalid), 32'(mr3.id));
                chk("lat3_rvalid_cycle", cyc, mr3.cyc);
                chk("lat3_rdata", bus3.rdata, mr3.data);
            end
        end
    end

    task automatic drive(input logic id, input logic req, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (id) begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end else begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end
    endtask

    // Issue nreq back-to-back accesses; req drops in each grant cycle and is
    // raised again the following cycle.
    task automatic req_op(input logic id, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int nreq);
        logic got;
        for (int k = 0; k < nreq; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            drive(id, 1'b1, we, addr, wdata);
            got = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                @(posedge clk); #1;
                if (id ? bus.m1_gnt : bus.m0_gnt) got = 1'b1;
            end
            drive(id, 1'b0, we, addr, wdata);
            chk("gnt_seen", 32'(got), 1);
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        chk("idle_reached", 32'(bus.busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        logic got;

        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        bus3.m0_req = 1'b0; bus3.m0_we = 1'b0; bus3.m0_addr = '0; bus3.m0_wdata = '0;
        bus3.m1_req = 1'b0; bus3.m1_we = 1'b0; bus3.m1_addr = '0; bus3.m1_wdata = '0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_gnt",    32'(bus.m0_gnt), 0);
        chk("rst_m1_gnt",    32'(bus.m1_gnt), 0);
        chk("rst_m0_rvalid", 32'(bus.m0_rvalid), 0);
        chk("rst_m1_rvalid", 32'(bus.m1_rvalid), 0);
        chk("rst_mem_w",     32'(bus.mem_w), 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_mem_dout",  bus.mem_dout, 0);
        chk("rst_rdata",     bus.rdata, 0);
        chk("rst_busy",      32'(bus.busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // m0 read 0x0010 -> 0xBEEF
        n = cyc;
        exp_gnt(1'b0, n + 1, 16'h0010, 16'h0, 1'b0);
        exp_rsp(1'b0, n + 3, 16'hBEEF);
        req_op(1'b0, 1'b0, 16'h0010, 16'h0, 1);
        @(negedge clk); chk("t1_busy_n1", 32'(bus.busy), 1);
        @(negedge clk); chk("t1_busy_n2", 32'(bus.busy), 1);
        @(negedge clk); chk("t1_busy_n3", 32'(bus.busy), 1);
        @(negedge clk); chk("t1_busy_n4", 32'(bus.busy), 0);
        @(posedge clk); #1;

        // m1 write 0x0FFF <- 0x1234
        n = cyc;
        exp_gnt(1'b1, n + 1, 16'h0FFF, 16'h1234, 1'b1);
        req_op(1'b1, 1'b1, 16'h0FFF, 16'h1234, 1);
        @(negedge clk); chk("t2_busy_n1", 32'(bus.busy), 1);
        @(negedge clk); chk("t2_busy_n2", 32'(bus.busy), 0);
        @(posedge clk); #1;

        // Both requesting continuously, two reads each
        n = cyc;
`ifdef ARB_FIXED_PRIO_EN
        exp_gnt(1'b0, n + 1,  16'h0001, 16'h0, 1'b0);
        exp_gnt(1'b0, n + 5,  16'h0001, 16'h0, 1'b0);
        exp_gnt(1'b1, n + 9,  16'h0002, 16'h0, 1'b0);
        exp_gnt(1'b1, n + 13, 16'h0002, 16'h0, 1'b0);
        exp_rsp(1'b0, n + 3,  16'h5A01);
        exp_rsp(1'b0, n + 7,  16'h5A01);
        exp_rsp(1'b1, n + 11, 16'h5A02);
        exp_rsp(1'b1, n + 15, 16'h5A02);
`else
        exp_gnt(1'b0, n + 1,  16'h0001, 16'h0, 1'b0);
        exp_gnt(1'b1, n + 5,  16'h0002, 16'h0, 1'b0);
        exp_gnt(1'b0, n + 9,  16'h0001, 16'h0, 1'b0);
        exp_gnt(1'b1, n + 13, 16'h0002, 16'h0, 1'b0);
        exp_rsp(1'b0, n + 3,  16'h5A01);
        exp_rsp(1'b1, n + 7,  16'h5A02);
        exp_rsp(1'b0, n + 11, 16'h5A01);
        exp_rsp(1'b1, n + 15, 16'h5A02);
`endif
        fork
            req_op(1'b0, 1'b0, 16'h0001, 16'h0, 2);
            req_op(1'b1, 1'b0, 16'h0002, 16'h0, 2);
        join
        wait_idle();

        // MEM_LAT=3 instance: m0 read 0x0010
        n = cyc;
        rq3.push_back('{id: 1'b0, cyc: n + 5, data: 16'hBEEF});
        bus3.m0_req = 1'b1; bus3.m0_we = 1'b0; bus3.m0_addr = 16'h0010;
        got = 1'b0;
        for (int t = 0; t < 30 && !got; t++) begin
            @(posedge clk); #1;
            if (bus3.m0_gnt) begin
                got = 1'b1;
                chk("lat3_gnt_cycle", cyc, n + 1);
            end
        end
        bus3.m0_req = 1'b0;
        chk("lat3_gnt_seen", 32'(got), 1);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!bus3.busy) break;
        end
        chk("lat3_idle", 32'(bus3.busy), 0);
        @(posedge clk); #1;

        // Reset while a read sits in WAIT: the read is dropped
        n = cyc;
        exp_gnt(1'b0, n + 1, 16'h0040, 16'h0, 1'b0);
        req_op(1'b0, 1'b0, 16'h0040, 16'h0, 1);
        @(posedge clk); #1;         // cycle n+2, WAIT
        rst = 1'b1;
        @(posedge clk); #1;         // cycle n+3
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_busy",   32'(bus.busy), 0);
        chk("rstw_mem_w",  32'(bus.mem_w), 0);
        chk("rstw_rvalid", 32'(bus.m0_rvalid | bus.m1_rvalid), 0);
        @(posedge clk); #1;
        n = cyc;
        exp_gnt(1'b1, n + 1, 16'h0002, 16'h0, 1'b0);
        exp_rsp(1'b1, n + 3, 16'h5A02);
        req_op(1'b1, 1'b0, 16'h0002, 16'h0, 1);
        wait_idle();

        // m1 pulses req for one cycle during an m0 write: ignored
        n = cyc;
        exp_gnt(1'b0, n + 1, 16'h0020, 16'hCAFE, 1'b1);
        req_op(1'b0, 1'b1, 16'h0020, 16'hCAFE, 1);
        drive(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
        repeat (4) @(negedge clk);
        chk("pulse_busy", 32'(bus.busy), 0);
        chk("pulse_mem_addr_hold", bus.mem_addr, 16'h0020);

        repeat (2) @(negedge clk);
        chk("gq_empty",  gq.size(),  0);
        chk("rq_empty",  rq.size(),  0);
        chk("rq3_empty", rq3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port synchronous memory.
- Requester 0 is the processor memory port; requester 1 is a DMA/peripheral engine.
- Accepts one request at a time, drives registered memory address, write data and write strobe, and counts out the read latency.
- Returns read data with a one-cycle valid pulse; round-robin fairness on ties.

Parameters:
- ADDR_W, 16, address width of requesters and memory
- DATA_W, 16, data width
- MEM_LAT, 1, memory read latency in cycles, address edge to data valid on mem_din; legal range 1..4

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- m0_req  in  1  requester 0 access request; held until m0_gnt
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_addr  in  ADDR_W  requester 0 address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_gnt  out  1  one-cycle grant pulse; request accepted
- m0_rvalid  out  1  one-cycle read-data-valid pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid: same as m0_*, for requester 1
- rdata  out  DATA_W  read data, shared; qualified by mX_rvalid
- mem_addr  out  ADDR_W  registered memory address
- mem_dout  out  DATA_W  registered memory write data
- mem_w  out  1  registered memory write strobe
- mem_din  in  DATA_W  memory read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - last-grant register = 1, so requester 0 wins the first tie
  - latency counter 0
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE, cycle N, any req high:
  - Winner: the only requester if one; if both, the one not in last-grant.
  - End of N: mem_addr/mem_dout/mem_w load the winner's addr/wdata/we.
  - End of N: winner's gnt goes high for cycle N+1 only; last-grant updates; winner id and we latched; go to ACCESS.
- IDLE, no req: stay; mem_w = 0; mem_addr and mem_dout hold their last value.
- ACCESS, cycle N+1:
  - Memory samples address/data/strobe at end of N+1.
  - Write: mem_w clears at end of N+1, next state IDLE; earliest next grant visible N+3.
  - Read: mem_w stays 0; counter loads MEM_LAT-1; next state WAIT.
- WAIT:
  - Counter 0: capture mem_din into rdata, go to RESP.
  - Counter nonzero: decrement, stay.
  - For MEM_LAT=1, capture occurs in cycle N+2.
- RESP:
  - Winner's rvalid is high for exactly this one cycle; rdata stable.
  - Next state IDLE.
  - rdata holds until the next read capture.
- Arbitration occurs only in IDLE. Requests arriving in other states wait; requesters must hold req/we/addr/wdata stable until gnt.
- req dropped before gnt: no access, no gnt.
- req still high the cycle gnt is seen counts as a new request only if still high when the state is next IDLE. Requesters drop req in the gnt cycle.
- Both req held continuously: grants strictly alternate 0,1,0,1.
- Never more than one gnt or rvalid high in any cycle. gnt and rvalid never go to the non-winner.
- Reset mid-operation:
  - Next cycle: IDLE, mem_w=0, no rvalid or gnt.
  - The pending read is dropped and its requester never gets rvalid.
- Address/data pass unmodified, no width conversion.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins ties; last-grant register is not implemented; requester 1 is served only when m0_req is low in IDLE.
- Undefined: round-robin as above.

Test Plan:
- Reset, then m0 read addr 0x0010 with memory model returning 0xBEEF (MEM_LAT=1) -> m0_gnt at N+1, mem_addr=0x0010 and mem_w=0 at N+1, m0_rvalid at N+3 with rdata=0xBEEF, busy high N+1..N+3.
- m1 write addr 0x0FFF data 0x1234 -> m1_gnt at N+1, mem_w=1 for exactly cycle N+1 with mem_addr=0x0FFF and mem_dout=0x1234, no rvalid, busy low at N+2.
- m0 and m1 both requesting continuously with reads of 0x0001/0x0002 -> grant order m0,m1,m0,m1; each rvalid goes to the matching requester with matching data. With ARB_FIXED_PRIO_EN defined -> m0 only until m0_req drops.
- MEM_LAT=3, m0 read -> rvalid exactly 5 cycles after the IDLE request cycle; rdata equals mem_din sampled 3 cycles after the address edge.
- Reset asserted in WAIT of a read -> next cycle busy=0, mem_w=0, no rvalid ever for that read; a fresh m1 request afterwards is granted normally.
- m1_req pulsed for one cycle while busy with an m0 write -> no m1_gnt, no memory access from m1.
